// File: rtl/axi_rd_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_fifo_if
//  Brief    : Push-side and read-beat-side signal bundle for axi_rd_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_rd_fifo_if #(
    parameter int AW = 4
);
    logic          ar_start;
    logic [7:0]    ar_len;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          r_ready;
    logic          r_valid;
    logic          r_last;
    logic [31:0]   data_out;
    logic          busy;
    logic [AW:0]   fifo_count;

    // Drives the buffer: core push side plus AR/R handshake qualifiers.
    modport master (
        output ar_start, ar_len, in_valid, in_data, r_ready,
        input  in_ready, r_valid, r_last, data_out, busy, fifo_count
    );

    // The buffer itself.
    modport slave (
        input  ar_start, ar_len, in_valid, in_data, r_ready,
        output in_ready, r_valid, r_last, data_out, busy, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_fifo
//  Brief    : Show-ahead word FIFO between the ML-DSA core and the AXI read
//             channel; each accepted read address releases ARLEN+1 beats.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_rd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    axi_rd_fifo_if.slave  bus
);
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_beat_cnt;
    logic [7:0]    r_beats_m1;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_start;
    logic          w_rvalid;
    logic          w_rlast;
    logic          w_busy;
    logic [31:0]   w_data;

    // Full blocks pushes even when a pop frees a slot in the same cycle.
    assign w_in_ready = (r_count != c_FULL);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = w_rvalid && bus.r_ready;

    // Read-side next state and show-ahead beat outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rvalid    = 1'b0;
        w_rlast     = 1'b0;
        w_busy      = 1'b0;
        w_data      = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.ar_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_busy   = 1'b1;
                w_rvalid = (r_count != '0);
                if (w_rvalid) begin
                    w_data  = r_mem[r_rptr];
                    w_rlast = (r_beat_cnt == r_beats_m1);
                end
                if (w_rvalid && bus.r_ready && w_rlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst length latch and beat counter; beat count holds while starved.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_beat_cnt <= 8'd0;
            r_beats_m1 <= 8'd0;
        end else if (w_start) begin
            r_beat_cnt <= 8'd0;
            r_beats_m1 <= bus.ar_len;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.r_valid    = w_rvalid;
    assign bus.r_last     = w_rlast;
    assign bus.data_out   = w_data;
    assign bus.busy       = w_busy;
    assign bus.fifo_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_axi_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rd_fifo
//  Brief    : Self-checking bench for axi_rd_fifo; a queue-based reference
//             model predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    axi_rd_fifo_if #(.AW(AW)) bus ();

    axi_rd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .ACLK    (clk),
        .ARESETn (rstn),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    int          push_budget;
    logic [31:0] word_seq = 32'h1000_0000;

    // Reference model: stored words in push order plus burst bookkeeping.
    logic [31:0] m_q [$];
    bit          m_busy = 1'b0;
    int          m_len  = 0;
    int          m_beat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the model, then advance the model across the
    // coming edge using the inputs that edge will sample.
    bit          e_rv, e_last, e_full, do_push, do_pop, was_busy;
    logic [31:0] e_data;
    always @(negedge clk) begin
        if (mon_en) begin
            e_full = (m_q.size() == DEPTH);
            e_rv   = m_busy && (m_q.size() != 0);
            e_last = e_rv && (m_beat == m_len);
            e_data = e_rv ? m_q[0] : 32'd0;
            check("in_ready",   32'(bus.in_ready),   32'(!e_full));
            check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
            check("busy",       32'(bus.busy),       32'(m_busy));
            check("r_valid",    32'(bus.r_valid),    32'(e_rv));
            check("r_last",     32'(bus.r_last),     32'(e_last));
            check("data_out",   bus.data_out,        e_data);
            if (!rstn) begin
                m_q.delete();
                m_busy = 1'b0;
                m_beat = 0;
            end else begin
                do_push  = bus.in_valid && !e_full;
                do_pop   = e_rv && bus.r_ready;
                was_busy = m_busy;
                if (do_pop) begin
                    void'(m_q.pop_front());
                    m_beat++;
                    if (e_last) m_busy = 1'b0;
                end
                if (do_push) m_q.push_back(bus.in_data);
                if (!was_busy && bus.ar_start) begin
                    m_busy = 1'b1;
                    m_len  = int'(bus.ar_len);
                    m_beat = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] d);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles at %0t", $time);
        end
    endtask

    task automatic start_burst(input logic [7:0] len);
        bus.ar_start = 1'b1;
        bus.ar_len   = len;
        tick();
        bus.ar_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (bus.busy) begin
            failures++;
            $display("FAIL burst_timeout: got busy=1 expected 0 within %0d cycles at %0t", budget, $time);
        end
    endtask

    // Random push/ready traffic for one burst; optionally pokes ar_start
    // mid-burst, which must be ignored.
    task automatic run_burst(input logic [7:0] len, input int push_pct,
                             input int ready_pct, input bit poke_ar);
        int budget = 6 * (int'(len) + 1) + 100;
        int k = 0;
        start_burst(len);
        while (bus.busy && k < budget) begin
            bus.in_valid = (push_budget > 0) && ($urandom_range(99) < push_pct);
            bus.in_data  = word_seq;
            bus.r_ready  = ($urandom_range(99) < ready_pct);
            bus.ar_start = poke_ar && ($urandom_range(9) == 0);
            bus.ar_len   = 8'($urandom_range(255));
            if (bus.in_valid && bus.in_ready) begin
                push_budget--;
                word_seq++;
            end
            tick();
            k++;
        end
        bus.in_valid = 1'b0;
        bus.r_ready  = 1'b0;
        bus.ar_start = 1'b0;
        checks++;
        if (bus.busy) begin
            failures++;
            $display("FAIL burst_timeout: got busy=1 expected 0 within %0d cycles at %0t", budget, $time);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        bus.ar_start = 1'b0;
        bus.ar_len   = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.r_ready  = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rstn = 1'b1;
        tick();

        // Basic four-beat burst with data already buffered.
        drive_push(32'h11); drive_push(32'h22); drive_push(32'h33); drive_push(32'h44);
        bus.r_ready = 1'b1;
        start_burst(8'd3);
        wait_idle(20);
        bus.r_ready = 1'b0;
        tick();

        // Burst started on an empty FIFO stalls until data arrives.
        bus.r_ready = 1'b1;
        start_burst(8'd1);
        tick(); tick(); tick();
        drive_push(32'hA5);
        drive_push(32'h5A);
        wait_idle(20);
        bus.r_ready = 1'b0;
        tick();

        // Full FIFO: push blocked during a same-cycle pop, taken next cycle.
        for (int i = 0; i < DEPTH; i++) drive_push(32'h300 + 32'(i));
        check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full_ready", 32'(bus.in_ready), 32'd0);
        start_burst(8'd0);
        bus.r_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3FF;
        tick();
        bus.r_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("refill_count", 32'(bus.fifo_count), 32'(DEPTH));
        bus.r_ready = 1'b1;
        start_burst(8'd15);
        wait_idle(40);
        bus.r_ready = 1'b0;
        tick();

        // Twenty words through two ten-beat bursts; pointers wrap.
        push_budget = 20;
        run_burst(8'd9, 60, 60, 1'b0);
        run_burst(8'd9, 60, 60, 1'b0);
        check("wrap_drained", 32'(bus.fifo_count), 32'd0);

        // ar_start mid-burst is ignored.
        drive_push(32'h51); drive_push(32'h52); drive_push(32'h53); drive_push(32'h54);
        bus.r_ready = 1'b1;
        start_burst(8'd3);
        bus.ar_start = 1'b1;
        bus.ar_len   = 8'd0;
        tick();
        bus.ar_start = 1'b0;
        check("ignored_ar_busy", 32'(bus.busy), 32'd1);
        wait_idle(20);
        bus.r_ready = 1'b0;
        tick();

        // Reset after two of four beats aborts the burst.
        drive_push(32'h61); drive_push(32'h62); drive_push(32'h63); drive_push(32'h64);
        bus.r_ready = 1'b1;
        start_burst(8'd3);
        tick(); tick();
        rstn        = 1'b0;
        bus.r_ready = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_busy",    32'(bus.busy),       32'd0);
        check("rst_rvalid",  32'(bus.r_valid),    32'd0);
        check("rst_count",   32'(bus.fifo_count), 32'd0);
        check("rst_inready", 32'(bus.in_ready),   32'd1);
        drive_push(32'h71); drive_push(32'h72);
        bus.r_ready = 1'b1;
        start_burst(8'd1);
        wait_idle(20);
        bus.r_ready = 1'b0;
        tick();

        // Randomised bursts including a maximum-length 256-beat burst.
        push_budget = 1_000_000;
        for (int b = 0; b < 8; b++) begin
            run_burst(8'($urandom_range(20)), 40 + int'($urandom_range(50)),
                      30 + int'($urandom_range(60)), 1'b1);
        end
        run_burst(8'd255, 70, 80, 1'b1);
        for (int b = 0; b < 4; b++) begin
            run_burst(8'($urandom_range(30)), 50, 50, 1'b1);
        end

        tick(); tick();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
